// File: rtl/rv_mem_pkg.sv
// Shared encodings for the data-memory access path: funct3 sizes, FSM states
// and lane helpers.
`ifndef XLEN
`define XLEN 32
`endif

package rv_mem_pkg;

    typedef enum logic [2:0] {
        F3Byte  = 3'b000,
        F3Half  = 3'b001,
        F3Word  = 3'b010,
        F3Dbl   = 3'b011,
        F3ByteU = 3'b100,
        F3HalfU = 3'b101,
        F3WordU = 3'b110
    } funct3_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    // Number of address bits that select a byte lane within one bus beat.
    function automatic int unsigned lane_off_width(int unsigned xlen);
        return $clog2(xlen / 8);
    endfunction

    // Doubleword and unsigned-word accesses exist only on a 64-bit datapath.
    function automatic logic size_supported(logic [2:0] f3, int unsigned xlen);
        logic ok;
        ok = 1'b1;
        if (f3 == 3'b111) begin
            ok = 1'b0;
        end else if ((f3 == F3Dbl || f3 == F3WordU) && xlen != 64) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Moves the addressed lane of a bus read beat down to bit 0 and applies
// sign or zero extension according to funct3.
module load_aligner
    import rv_mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]                  rdata,
    input  logic [lane_off_width(XLEN)-1:0]  offset,
    input  logic [2:0]                       funct3,
    output logic [XLEN-1:0]                  data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3Byte:  data = XLEN'($signed(shifted[7:0]));
            F3Half:  data = XLEN'($signed(shifted[15:0]));
            // On a 32-bit datapath this is a plain pass-through.
            F3Word:  data = XLEN'($signed(shifted[31:0]));
            F3ByteU: data = XLEN'(shifted[7:0]);
            F3HalfU: data = XLEN'(shifted[15:0]);
            F3WordU: data = XLEN'(shifted[31:0]);
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: checks alignment, issues one bus
// request per load/store, stalls the pipe until the response and reports faults.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_access_unit
    import rv_mem_pkg::*;
#(
    parameter int unsigned XLEN = `XLEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [2:0]        funct3,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [XLEN-1:0]   bus_addr,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_rsp_valid,
    input  logic              bus_rsp_err,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              stall,
    output logic [XLEN-1:0]   load_data,
    output logic              done,
    output logic              exc,
    output logic              exc_misaligned,
    output logic              exc_is_store,
    output logic [XLEN-1:0]   exc_addr
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = lane_off_width(XLEN);

    state_e          state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      funct3_q;
    logic            we_q;

    logic is_access, supported, aligned, start, bad;

    always_comb begin
        is_access = reset_n && (state_q == StIdle) && valid && (mem_read || mem_write);
        supported = size_supported(funct3, XLEN);
        unique case (funct3[1:0])
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~addr[0];
            2'd2:    aligned = (addr[1:0] == 2'b00);
            default: aligned = (addr[2:0] == 3'b000);
        endcase
        start = is_access && supported && aligned;
        bad   = is_access && !(supported && aligned);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        funct3_q <= funct3;
                        // A simultaneous read and write request is a write.
                        we_q     <= mem_write;
                        state_q  <= StReq;
                    end
                end
                StReq: begin
                    if (bus_req_ready) state_q <= StWait;
                end
                StWait: begin
                    if (bus_rsp_valid) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic [NB-1:0]   size_mask;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] aligned_data;
    logic            in_req, rsp_fault;

    load_aligner #(
        .XLEN(XLEN)
    ) u_load_aligner (
        .rdata (bus_rdata),
        .offset(addr_q[OW-1:0]),
        .funct3(funct3_q),
        .data  (aligned_data)
    );

    always_comb begin
        unique case (funct3_q[1:0])
            2'd0: begin
                size_mask = NB'(1);
                wdata_rep = {NB{wdata_q[7:0]}};
            end
            2'd1: begin
                size_mask = NB'(3);
                wdata_rep = {(NB/2){wdata_q[15:0]}};
            end
            2'd2: begin
                size_mask = NB'(15);
                wdata_rep = {(NB/4){wdata_q[31:0]}};
            end
            default: begin
                size_mask = '1;
                wdata_rep = wdata_q;
            end
        endcase

        in_req    = (state_q == StReq);
        done      = (state_q == StWait) && bus_rsp_valid;
        rsp_fault = done && bus_rsp_err;

        bus_req_valid = in_req;
        bus_addr      = in_req ? {addr_q[XLEN-1:OW], {OW{1'b0}}} : '0;
        bus_we        = in_req && we_q;
        bus_wstrb     = (in_req && we_q) ? (size_mask << addr_q[OW-1:0]) : '0;
        bus_wdata     = (in_req && we_q) ? wdata_rep : '0;

        stall     = start || in_req || ((state_q == StWait) && !bus_rsp_valid);
        load_data = (done && !we_q && !bus_rsp_err) ? aligned_data : '0;

        exc            = bad || rsp_fault;
        exc_misaligned = bad;
        exc_is_store   = bad ? mem_write : (rsp_fault && we_q);
        exc_addr       = bad ? addr : (rsp_fault ? addr_q : '0);
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized scoreboard bench for dmem_access_unit; drives a 32-bit and a
// 64-bit instance through a shared stimulus port selected per access.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [63:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic [2:0]  funct3 = '0;
    logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;

    always #5 clk = ~clk;

    logic        d32_rv, d32_we, d32_stall, d32_done, d32_exc, d32_mis, d32_st;
    logic [31:0] d32_baddr, d32_bwdata, d32_ld, d32_eaddr;
    logic [3:0]  d32_wstrb;
    logic        d64_rv, d64_we, d64_stall, d64_done, d64_exc, d64_mis, d64_st;
    logic [63:0] d64_baddr, d64_bwdata, d64_ld, d64_eaddr;
    logic [7:0]  d64_wstrb;

    dmem_access_unit #(.XLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .valid(valid & ~sel), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr[31:0]), .wdata(wdata[31:0]), .funct3(funct3),
        .bus_req_valid(d32_rv), .bus_req_ready(bus_req_ready), .bus_addr(d32_baddr),
        .bus_we(d32_we), .bus_wdata(d32_bwdata), .bus_wstrb(d32_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_err(bus_rsp_err), .bus_rdata(bus_rdata[31:0]),
        .stall(d32_stall), .load_data(d32_ld), .done(d32_done), .exc(d32_exc),
        .exc_misaligned(d32_mis), .exc_is_store(d32_st), .exc_addr(d32_eaddr)
    );

    dmem_access_unit #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .valid(valid & sel), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .wdata(wdata), .funct3(funct3),
        .bus_req_valid(d64_rv), .bus_req_ready(bus_req_ready), .bus_addr(d64_baddr),
        .bus_we(d64_we), .bus_wdata(d64_bwdata), .bus_wstrb(d64_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_err(bus_rsp_err), .bus_rdata(bus_rdata),
        .stall(d64_stall), .load_data(d64_ld), .done(d64_done), .exc(d64_exc),
        .exc_misaligned(d64_mis), .exc_is_store(d64_st), .exc_addr(d64_eaddr)
    );

    // Outputs of whichever instance the current access targets.
    logic        o_rv, o_we, o_stall, o_done, o_exc, o_mis, o_st;
    logic [63:0] o_baddr, o_bwdata, o_ld, o_eaddr;
    logic [7:0]  o_wstrb;
    always_comb begin
        o_rv     = sel ? d64_rv    : d32_rv;
        o_we     = sel ? d64_we    : d32_we;
        o_stall  = sel ? d64_stall : d32_stall;
        o_done   = sel ? d64_done  : d32_done;
        o_exc    = sel ? d64_exc   : d32_exc;
        o_mis    = sel ? d64_mis   : d32_mis;
        o_st     = sel ? d64_st    : d32_st;
        o_baddr  = sel ? d64_baddr : {32'b0, d32_baddr};
        o_bwdata = sel ? d64_bwdata : {32'b0, d32_bwdata};
        o_ld     = sel ? d64_ld    : {32'b0, d32_ld};
        o_eaddr  = sel ? d64_eaddr : {32'b0, d32_eaddr};
        o_wstrb  = sel ? d64_wstrb : {4'b0, d32_wstrb};
    end

    typedef struct {
        bit          dn, exc, mis, st;
        logic [63:0] eaddr, ld;
        int          stalls;
    } exp_t;

    typedef struct {
        logic [63:0] addr, wdata;
        logic        we;
        logic [7:0]  wstrb;
    } bexp_t;

    exp_t  exp_q[$];
    bexp_t bus_q[$];
    int    n_chk = 0, n_fail = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // Reference model: byte-level view of the access, independent of any lane logic.
    function automatic void model(input bit s64, input bit wr, input logic [2:0] f3,
                                  input logic [63:0] a, w, r, input int R, W,
                                  input bit err, output exp_t e, output bexp_t b,
                                  output bit ok);
        int unsigned nb, sz, off;
        logic [63:0] xm, v, szm;
        nb  = s64 ? 8 : 4;
        xm  = s64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sz  = 1 << f3[1:0];
        ok  = (f3 != 3'd7) && !((f3 == 3'd3 || f3 == 3'd6) && !s64) && ((a % sz) == 0);
        off = int'(a % nb);
        e   = '{dn: 1'b0, exc: 1'b0, mis: 1'b0, st: 1'b0, eaddr: '0, ld: '0, stalls: 0};
        b   = '{addr: '0, wdata: '0, we: 1'b0, wstrb: '0};
        if (!ok) begin
            e.exc = 1'b1; e.mis = 1'b1; e.st = wr; e.eaddr = a;
            return;
        end
        szm = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 1);
        v = ((r & xm) >> (8 * off)) & szm;
        if (!f3[2] && sz < nb && v[8*sz-1]) v = v | ~szm;
        v = v & xm;
        e.dn = 1'b1;
        e.stalls = 1 + (R + 1) + W;
        e.exc = err;
        e.st = err && wr;
        e.eaddr = err ? a : 64'd0;
        e.ld = (err || wr) ? 64'd0 : v;
        b.addr = a - off;
        b.we = wr;
        if (wr) begin
            b.wstrb = 8'(((1 << sz) - 1) << off);
            for (int i = 0; i < int'(nb); i++) b.wdata[8*i +: 8] = w[8*(i % int'(sz)) +: 8];
        end
    endfunction

    // Response monitor.
    int stall_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            stall_cnt = 0;
        end else if (o_done || o_exc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {o_done, o_exc}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done", o_done, e.dn);
                chk("exc", o_exc, e.exc);
                chk("exc_misaligned", o_mis, e.mis);
                chk("exc_is_store", o_st, e.st);
                chk("exc_addr", o_eaddr, e.eaddr);
                chk("load_data", o_ld, e.ld);
                chk("stall_at_event", o_stall, 1'b0);
                chk("stall_cycles", stall_cnt, e.stalls);
            end
            stall_cnt = 0;
        end else begin
            if (o_stall) stall_cnt++;
            if (o_ld != 64'd0) chk("load_data_idle", o_ld, 64'd0);
        end
    end

    // Bus-request monitor: payload must match the head entry every cycle it is offered.
    always @(negedge clk) begin
        if (reset_n && o_rv) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_req", o_rv, 1'b0);
            end else begin
                chk("bus_addr", o_baddr, bus_q[0].addr);
                chk("bus_we", o_we, bus_q[0].we);
                chk("bus_wstrb", o_wstrb, bus_q[0].wstrb);
                if (bus_q[0].we) chk("bus_wdata", o_bwdata, bus_q[0].wdata);
                if (bus_req_ready) void'(bus_q.pop_front());
            end
        end
    end

    // Inputs other than the request itself are irrelevant once the access is latched.
    task automatic scramble();
        valid     = 1'($urandom_range(1));
        mem_read  = 1'($urandom_range(1));
        mem_write = 1'($urandom_range(1));
        funct3    = 3'($urandom_range(7));
        addr      = {$urandom, $urandom};
        wdata     = {$urandom, $urandom};
    endtask

    // Called at posedge+1; returns at posedge+1 with the unit back in IDLE.
    task automatic do_access(input bit s64, input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [63:0] a_in, input logic [63:0] w_in,
                             input logic [63:0] r, input int R, input int W, input bit err);
        exp_t e; bexp_t b; bit ok;
        logic [63:0] xm, a, w;
        xm = s64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a = a_in & xm;
        w = w_in & xm;
        model(s64, wr, f3, a, w, r, R, W, err, e, b, ok);
        exp_q.push_back(e);
        if (ok) bus_q.push_back(b);
        sel = s64; valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; wdata = w;
        @(posedge clk); #1;
        if (!ok) begin
            valid = 1'b0;
            return;
        end
        for (int i = 0; i <= R; i++) begin
            scramble();
            bus_req_ready = (i == R);
            bus_rsp_valid = 1'($urandom_range(1));
            bus_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus_req_ready = 1'b0;
        for (int i = 0; i <= W; i++) begin
            scramble();
            bus_rsp_valid = (i == W);
            bus_rsp_err = err && (i == W);
            bus_rdata = (i == W) ? r : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        valid = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_err = 1'b0;
        bus_req_ready = 1'($urandom_range(1));
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_stall32"}, {d32_stall, d32_done, d32_exc, d32_mis, d32_st, d32_rv}, 64'd0);
        chk({tag, "_data32"}, {d32_ld, d32_eaddr}, 64'd0);
        chk({tag, "_bus32"}, {d32_baddr, d32_wstrb, d32_we}, 64'd0);
        chk({tag, "_stall64"}, {d64_stall, d64_done, d64_exc, d64_mis, d64_st, d64_rv}, 64'd0);
        chk({tag, "_data64"}, d64_ld | d64_eaddr, 64'd0);
        chk({tag, "_bus64"}, d64_baddr | {55'd0, d64_wstrb, d64_we}, 64'd0);
    endtask

    // Abandon an access in WAIT by an asynchronous reset, then offer a stale response.
    task automatic reset_in_wait();
        sel = 1'b0; valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; addr = 64'h100;
        bus_q.push_back('{addr: 64'h100, wdata: '0, we: 1'b0, wstrb: '0});
        @(posedge clk); #1;
        valid = 1'b0; bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset_in_wait");
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b1; bus_rdata = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("late_rsp_done", d32_done, 1'b0);
        chk("late_rsp_stall", d32_stall, 1'b0);
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
    endtask

    initial begin
        // Misaligned request held during reset must not raise exc.
        sel = 1'b0; valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 64'h101;
        #12 check_all_zero("in_reset");
        valid = 1'b0;
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        do_access(0, 1, 0, 3'b010, 64'h100, 0, 64'hDEAD_BEEF, 0, 0, 0);            // LW
        do_access(0, 1, 0, 3'b000, 64'h103, 0, 64'h80FF_0000, 0, 0, 0);            // LB
        do_access(0, 1, 0, 3'b100, 64'h103, 0, 64'h80FF_0000, 0, 0, 0);            // LBU
        do_access(0, 0, 1, 3'b001, 64'h202, 64'h1234_ABCD, 0, 0, 0, 0);            // SH
        do_access(0, 1, 0, 3'b010, 64'h101, 0, 0, 0, 0, 0);                        // LW misaligned
        do_access(0, 0, 1, 3'b010, 64'h300, 64'hCAFE_F00D, 0, 5, 0, 1);            // SW bus fault
        do_access(0, 1, 0, 3'b011, 64'h8, 0, 0, 0, 0, 0);                          // LD on RV32
        do_access(0, 1, 0, 3'b111, 64'h0, 0, 0, 0, 0, 0);                          // funct3 111
        do_access(0, 1, 1, 3'b000, 64'h401, 64'h5A, 0, 1, 2, 0);                   // rd+wr = store
        reset_in_wait();
        do_access(1, 1, 0, 3'b110, 64'h4, 0, 64'hF000_0001_0000_0000, 0, 0, 0);    // LWU RV64
        do_access(1, 1, 0, 3'b010, 64'h4, 0, 64'hF000_0001_0000_0000, 0, 1, 0);    // LW RV64
        do_access(1, 0, 1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 0, 2, 1, 0);   // SD
        do_access(1, 1, 0, 3'b011, 64'h1C, 0, 0, 0, 0, 0);                         // LD misaligned

        for (int n = 0; n < 300; n++) begin
            bit s64, rd, wr;
            logic [2:0] f3;
            logic [63:0] a;
            s64 = 1'($urandom_range(1));
            f3 = 3'($urandom_range(7));
            rd = 1'($urandom_range(1));
            wr = rd ? 1'($urandom_range(1)) : 1'b1;
            a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a = a & ~((64'd1 << f3[1:0]) - 1);
            if ($urandom_range(9) == 0) begin
                // Idle or non-memory cycle: nothing may happen.
                sel = s64; valid = 1'($urandom_range(1)); mem_read = 1'b0; mem_write = 1'b0;
                @(posedge clk); #1;
                valid = 1'b0;
            end else begin
                do_access(s64, rd, wr, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                          $urandom_range(3), $urandom_range(3), ($urandom_range(7) == 0));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pending_responses", exp_q.size(), 64'd0);
        chk("pending_bus_reqs", bus_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter: XLEN, default `XLEN (32 or 64), data/address width.
REQ-002 Port: clk  in  1  single clock, rising edge.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: valid, mem_read, mem_write  in  1 each  access request from the EX/MEM register outputs.
REQ-005 Port: addr  in  XLEN  effective address (EX/MEM alu_result); wdata  in  XLEN  store data; funct3  in  3  size/signedness.
REQ-006 Port: bus_req_valid  out  1; bus_req_ready  in  1; bus_addr  out  XLEN, aligned down to XLEN/8 bytes; bus_we  out  1; bus_wdata  out  XLEN; bus_wstrb  out  XLEN/8.
REQ-007 Port: bus_rsp_valid  in  1; bus_rsp_err  in  1; bus_rdata  in  XLEN.
REQ-008 Port: stall  out  1  drives EX/MEM hold; load_data  out  XLEN  extended load result; done  out  1  access complete.
REQ-009 Port: exc  out  1; exc_misaligned  out  1 (0 = bus fault); exc_is_store  out  1; exc_addr  out  XLEN.

Function
REQ-010 FSM states IDLE, REQ, WAIT; all other encodings recover to IDLE.
REQ-011 start = valid & (mem_read | mem_write) & aligned & size supported; mem_read and mem_write both high: treat as write.
REQ-012 Alignment: byte any; half addr[0]=0; word addr[1:0]=0; double addr[2:0]=0.
REQ-013 Supported funct3: 000,001,010,100,101 always; 011,110 only when XLEN=64; 111 never; unsupported size reports exc with exc_misaligned=1.
REQ-014 IDLE, misaligned/unsupported valid access: exc=1 combinationally same cycle, no bus request, stall=0, stay IDLE.
REQ-015 IDLE, start: latch addr, wdata, funct3, we; stall=1 same cycle; next state REQ.
REQ-016 REQ: bus_req_valid=1 with stable latched payload until bus_req_ready; handshake cycle -> WAIT; stall=1.
REQ-017 WAIT: stall=1 until bus_rsp_valid; response cycle: stall=0, done=1 for exactly that cycle, state -> IDLE.
REQ-018 Response with bus_rsp_err=1: done=1, exc=1, exc_misaligned=0, exc_addr=latched addr, load_data=0.
REQ-019 bus_rsp_valid outside WAIT is ignored; bus_req_ready outside REQ is ignored.
REQ-020 Stores: bus_wstrb = size mask (1/3/F/FF) shifted left by addr[log2(XLEN/8)-1:0]; bus_wdata = store data replicated into every lane of its size.
REQ-021 Loads: bus_wstrb=0; bus_rdata shifted right by 8*offset, then sign-extend (000,001,010 on RV64) or zero-extend (100,101,110); 010 on RV32 and 011 pass through unchanged.
REQ-022 load_data valid only while done=1; 0 otherwise; stores give load_data=0.
REQ-023 exc_is_store = we of the faulting access; exc_addr = unaligned original address.
REQ-024 Latency: one-cycle ready and response gives stall for 2 cycles, done on cycle 3 after start.
REQ-025 Inputs sampled only in IDLE; input changes during REQ/WAIT have no effect.

Reset
REQ-026 reset_n low: state IDLE, latched fields 0, every output 0, asynchronously, independent of clk.
REQ-027 Reset during REQ or WAIT abandons the access; no done, no exc; any late response is ignored per REQ-019.

Structure
REQ-028 Shared package rv_mem_pkg: funct3 size/sign encodings, FSM state encodings, lane-offset width function.
REQ-029 One combinational sub-module, load_aligner: lane shift plus sign/zero extension, parameterized by XLEN.
REQ-030 Implementation size 120-400 lines; no memories; registers only for state and latched request.

Verification (XLEN=32 unless stated)
REQ-031 LW addr 0x100, ready and rsp next cycles, rdata 0xDEADBEEF -> stall 2 cycles, done 1 cycle, load_data 0xDEADBEEF.
REQ-032 LB addr 0x103, rdata 0x80FF_0000 -> load_data 0xFFFFFF80; same with LBU -> 0x00000080.
REQ-033 SH addr 0x202, wdata 0x1234ABCD -> bus_addr 0x200, wstrb 0xC, wdata 0xABCDABCD, done on response.
REQ-034 LW addr 0x101 -> exc=1, exc_misaligned=1, exc_is_store=0, exc_addr 0x101 same cycle, no bus_req_valid, stall=0.
REQ-035 SW with ready held low 5 cycles then rsp_err=1 -> bus_req_valid and payload stable 5 cycles, then exc=1, exc_misaligned=0, done=1.
REQ-036 reset_n low in WAIT, then rsp_valid after release -> outputs 0, state IDLE, no done; XLEN=64 LWU addr 0x4, rdata 0xF000000100000000 -> load_data 0x00000000F0000001.
